// File: rtl/dffram_ctl.sv
// Single-port word RAM controller with byte enables, read-before-write and an optional
// output pipeline stage. After reset it can sweep the array to zero before taking requests.
module dffram_ctl #(
    parameter int WORDS          = 256,
    parameter int WSIZE          = 4,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(WORDS),
    localparam int DW            = 8 * WSIZE
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [WSIZE-1:0] WE,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    Di,
    output logic [DW-1:0]    Do,
    output logic             VLD,
    output logic             RDY,
    output logic             BUSY
);

    // state   | meaning
    // S_CLEAR | zero-fill sweep running, requests ignored
    // S_RUN   | normal operation, one request per cycle
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    state_t          state_q;
    logic [AW-1:0]   clr_addr_q;
    logic            rdy_q;
    logic            busy_q;
    logic [DW-1:0]   rd_data_q;
    logic            rd_vld_q;
    logic [DW-1:0]   mem [WORDS];
    logic            accept;
    logic            clr_we;

    // Gating with RST_N keeps the array untouched by edges that arrive while reset is held.
    assign accept = EN & rdy_q & RST_N;
    assign clr_we = (state_q == S_CLEAR) & RST_N;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_addr_q <= '0;
            rdy_q      <= (CLEAR_ON_RESET == 0);
            busy_q     <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + AW'(1);
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= S_RUN;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    // Array has no reset; only the sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (accept) begin
            for (int b = 0; b < WSIZE; b++) begin
                if (WE[b]) begin
                    mem[A][8*b +: 8] <= Di[8*b +: 8];
                end
            end
        end
    end

    // Non-blocking update of mem means this captures the pre-write word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= accept;
            if (accept) begin
                rd_data_q <= mem[A];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] out_data_q;
            logic          out_vld_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    out_data_q <= '0;
                    out_vld_q  <= 1'b0;
                end else begin
                    out_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign Do  = out_data_q;
            assign VLD = out_vld_q;
        end else begin : g_no_out_reg
            assign Do  = rd_data_q;
            assign VLD = rd_vld_q;
        end
    endgenerate

    assign RDY  = rdy_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_dffram_ctl.sv
// Directed bench for dffram_ctl: three instances share stimulus (OUT_REG=0, OUT_REG=1,
// and no clear-on-reset) and are compared against hand-computed values and a word model.
module tb_dffram_ctl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
    logic [31:0] do0, do1, do2;
    logic        vld0, vld1, vld2;
    logic        rdy0, rdy1, rdy2;
    logic        busy0, busy1, busy2;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] model [256];
    logic [7:0]  sa [16];
    logic [3:0]  sw [16];
    logic [31:0] sd [16];
    logic [31:0] se [16];

    dffram_ctl #(.WORDS(256), .WSIZE(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .WE(we), .A(a), .Di(di),
        .Do(do0), .VLD(vld0), .RDY(rdy0), .BUSY(busy0));

    dffram_ctl #(.WORDS(256), .WSIZE(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .WE(we), .A(a), .Di(di),
        .Do(do1), .VLD(vld1), .RDY(rdy1), .BUSY(busy1));

    dffram_ctl #(.WORDS(256), .WSIZE(4), .OUT_REG(0), .CLEAR_ON_RESET(0)) dut2 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .WE(we), .A(a), .Di(di),
        .Do(do2), .VLD(vld2), .RDY(rdy2), .BUSY(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [7:0] ad, input logic [3:0] w, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) model[ad][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Wait for RDY after a reset release; VLD must stay low for the whole sweep.
    task automatic wait_fill(input string tag);
        int   cnt;
        logic vflag;
        cnt   = 0;
        vflag = 1'b0;
        while (!rdy0 && cnt < 400) begin
            tick();
            cnt++;
            if (!rdy0 && busy0 !== 1'b1) vflag = 1'b1;
            if (vld0 || vld1) vflag = 1'b1;
        end
        en = 1'b0;
        check({tag, "_cycles"}, cnt, 256);
        check({tag, "_vld_or_busy_glitch"}, {31'b0, vflag}, 0);
        check({tag, "_rdy"}, {31'b0, rdy0}, 1);
        check({tag, "_busy"}, {31'b0, busy0}, 0);
        check({tag, "_rdy_reg"}, {31'b0, rdy1}, 1);
    endtask

    task automatic single(input string tag, input logic [7:0] ad, input logic [3:0] w,
                          input logic [31:0] d);
        logic [31:0] e;
        e = model[ad];
        model_apply(ad, w, d);
        a = ad; we = w; di = d; en = 1'b1;
        tick();
        en = 1'b0;
        check({tag, "_vld0"}, {31'b0, vld0}, 1);
        check({tag, "_do0"}, do0, e);
        check({tag, "_vld1_early"}, {31'b0, vld1}, 0);
        tick();
        check({tag, "_vld1"}, {31'b0, vld1}, 1);
        check({tag, "_do1"}, do1, e);
        check({tag, "_vld0_idle"}, {31'b0, vld0}, 0);
        check({tag, "_do0_hold"}, do0, e);
    endtask

    task automatic run_stream(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            se[k] = model[sa[k]];
            model_apply(sa[k], sw[k], sd[k]);
        end
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                a = sa[k]; we = sw[k]; di = sd[k]; en = 1'b1;
            end else begin
                en = 1'b0;
            end
            tick();
            if (k < n) begin
                check({tag, "_vld0"}, {31'b0, vld0}, 1);
                check({tag, "_do0"}, do0, se[k]);
            end else begin
                check({tag, "_vld0_end"}, {31'b0, vld0}, 0);
            end
            if (k >= 1 && k <= n) begin
                check({tag, "_vld1"}, {31'b0, vld1}, 1);
                check({tag, "_do1"}, do1, se[k-1]);
            end else begin
                check({tag, "_vld1_off"}, {31'b0, vld1}, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; we = 4'h0; a = 8'h0; di = 32'h0;
        model_zero();
        #1 rst_n = 1'b0;
        #1;
        check("rst_do", do0, 0);
        check("rst_vld", {31'b0, vld0}, 0);
        check("rst_busy", {31'b0, busy0}, 1);
        check("rst_rdy", {31'b0, rdy0}, 0);
        check("rst_do_reg", do1, 0);
        check("rst_noclr_rdy", {31'b0, rdy2}, 1);
        check("rst_noclr_busy", {31'b0, busy2}, 0);
        tick(); tick();
        check("rst_held_busy", {31'b0, busy0}, 1);

        // Requests during the sweep must be ignored and never queued.
        a = 8'd9; we = 4'hF; di = 32'hFFFF_FFFF; en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("midfill_busy", {31'b0, busy0}, 1);
        check("midfill_vld", {31'b0, vld0 | vld1}, 0);
        rst_n = 1'b0;
        #1;
        check("midfill_rst_do", do0, 0);
        check("midfill_rst_vld", {31'b0, vld0}, 0);
        check("midfill_rst_busy", {31'b0, busy0}, 1);
        tick();
        rst_n = 1'b1;
        wait_fill("fill1");

        single("rd7f", 8'h7F, 4'h0, 32'h0);
        single("rd9", 8'd9, 4'h0, 32'h0);
        check("rd9_zero", do0, 32'h0);

        single("be_w1", 8'd5, 4'hF, 32'hAABB_CCDD);
        single("be_w2", 8'd5, 4'b0101, 32'h1122_3344);
        check("be_w2_old", do0, 32'hAABB_CCDD);
        single("be_rd", 8'd5, 4'h0, 32'h0);
        check("be_final", do0, 32'hAA22_CC44);
        check("be_noclr_do", do2, 32'hAA22_CC44);

        single("rbw_w", 8'd3, 4'hF, 32'hDEAD_BEEF);
        check("rbw_old", do0, 32'h0);
        single("rbw_rd", 8'd3, 4'h0, 32'h0);
        check("rbw_new", do0, 32'hDEAD_BEEF);

        for (int k = 0; k < 8; k++) begin
            sa[k] = 8'(k); sw[k] = 4'hF; sd[k] = 32'h0101_0101 * (k + 1);
        end
        sa[8] = 8'd10; sw[8] = 4'b0011; sd[8] = 32'hCAFE_F00D;
        sa[9] = 8'd10; sw[9] = 4'h0;    sd[9] = 32'h0;
        run_stream("wstream", 10);
        check("w_then_r", se[9], 32'h0000_F00D);

        for (int k = 0; k < 8; k++) begin
            sa[k] = 8'(k); sw[k] = 4'h0; sd[k] = 32'h0;
        end
        run_stream("rstream", 8);
        check("rstream_last", do1, 32'h0808_0808);

        // Reset while a read sits in the output pipeline stage.
        a = 8'd5; we = 4'h0; en = 1'b1;
        tick();
        en = 1'b0;
        check("inflight_vld0", {31'b0, vld0}, 1);
        rst_n = 1'b0;
        #1;
        check("inflight_rst_do0", do0, 0);
        check("inflight_rst_vld0", {31'b0, vld0}, 0);
        check("inflight_rst_do1", do1, 0);
        check("inflight_rst_vld1", {31'b0, vld1}, 0);
        tick();
        check("inflight_vld1_dropped", {31'b0, vld1}, 0);
        rst_n = 1'b1;
        model_zero();
        wait_fill("fill2");
        single("post_clr", 8'd5, 4'h0, 32'h0);
        check("post_clr_zero", do0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
